// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the phase sequencer and the sensor/light layer.
//   sensor       : per-phase vehicle request (bit i = phase i waiting)
//   lights       : 2 bits per phase at [2i+1:2i]; 10 green, 01 yellow, 00 red
//   active_phase : phase currently green/yellow, last served phase when idle
//   busy         : high while any phase is green or yellow
//   phase_start  : one-cycle pulse on the first green cycle of each phase
// master = sequencer side, slave = sensor/display side.
interface traffic_phase_ctrl_if #(
   parameter int NUM_PHASES = 3
);
   localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

   logic [NUM_PHASES-1:0]   sensor;
   logic [2*NUM_PHASES-1:0] lights;
   logic [PW-1:0]           active_phase;
   logic                    busy;
   logic                    phase_start;

   modport master (
      input  sensor,
      output lights, active_phase, busy, phase_start
   );

   modport slave (
      output sensor,
      input  lights, active_phase, busy, phase_start
   );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Sensor-driven round-robin traffic-light sequencer.
// Ports:
//   clk     : system clock, all state on rising edge
//   reset_n : asynchronous active-low reset (all red, idle)
//   bus     : traffic_phase_ctrl_if.master (sensor in; lights, active_phase,
//             busy, phase_start out)
// All outputs decode from registered state, so sensor never reaches an
// output combinationally and reset forces all-red immediately.
//
// state  | meaning
// IDLE   | all red, waiting for any request
// GREEN  | phase_q green, timer_q counts green cycles already elapsed
// YELLOW | phase_q yellow, timer_q counts yellow cycles already elapsed
module traffic_phase_ctrl #(
   parameter int NUM_PHASES  = 3,
   parameter int GREEN_MIN   = 4,
   parameter int GREEN_MAX   = 8,
   parameter int YELLOW_TIME = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   traffic_phase_ctrl_if.master bus
);

   localparam int PW   = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
   localparam int TMAX = (GREEN_MAX > YELLOW_TIME) ? GREEN_MAX : YELLOW_TIME;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
   localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_TIME - 1);
   localparam logic [TW-1:0] T_SAT  = {TW{1'b1}};
   localparam logic [PW-1:0] P_LAST = PW'(NUM_PHASES - 1);

   if (NUM_PHASES < 2 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN ||
       YELLOW_TIME < 1) begin : g_bad_params
      $error("traffic_phase_ctrl: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GREEN  = 2'd1,
      YELLOW = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic            start_q, start_d;

   logic [PW-1:0]   rr_pick;
   logic            rr_found;
   logic            any_req;
   logic            other_req;
   logic            green_end;
   logic [2*NUM_PHASES-1:0] lights_c;

   // Round-robin: first requester after phase_q, wrapping, ending at phase_q.
   always_comb begin
      int idx;
      idx      = 0;
      rr_found = 1'b0;
      rr_pick  = phase_q;
      for (int k = 1; k <= NUM_PHASES; k++) begin
         idx = int'(phase_q) + k;
         if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
         if (!rr_found && bus.sensor[idx]) begin
            rr_found = 1'b1;
            rr_pick  = PW'(idx);
         end
      end
   end

   assign any_req   = |bus.sensor;
   assign other_req = |(bus.sensor & ~({{(NUM_PHASES-1){1'b0}}, 1'b1} << phase_q));
   assign green_end = ((timer_q >= T_GMIN) && (other_req || !bus.sensor[phase_q])) ||
                      (timer_q == T_GMAX);

   always_comb begin
      state_d = state_q;
      timer_d = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
      phase_d = phase_q;
      start_d = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (any_req) begin
               state_d = GREEN;
               phase_d = rr_pick;
               start_d = 1'b1;
            end
         end
         GREEN: begin
            if (green_end) begin
               state_d = YELLOW;
               timer_d = '0;
            end
         end
         YELLOW: begin
            // phase_q stays put on the way to IDLE, so it doubles as last_phase.
            if (timer_q == T_YEL) begin
               timer_d = '0;
               if (any_req) begin
                  state_d = GREEN;
                  phase_d = rr_pick;
                  start_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         phase_q <= P_LAST;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         phase_q <= phase_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      lights_c = '0;
      if (state_q == GREEN)  lights_c[2*phase_q +: 2] = 2'b10;
      if (state_q == YELLOW) lights_c[2*phase_q +: 2] = 2'b01;
   end

   assign bus.lights       = lights_c;
   assign bus.active_phase = phase_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.phase_start  = start_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

   localparam int N    = 3;
   localparam int GMIN = 4;
   localparam int GMAX = 8;
   localparam int YT   = 2;

   localparam int M_IDLE = 0;
   localparam int M_GRN  = 1;
   localparam int M_YEL  = 2;

   logic clk;
   logic reset_n;

   traffic_phase_ctrl_if #(.NUM_PHASES(N)) bus();

   traffic_phase_ctrl #(
      .NUM_PHASES(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_TIME(YT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: which light is showing, for which phase, and how many
   // cycles of that light have been shown so far.
   int m_mode, m_phase, m_last, m_cnt;
   logic m_start;
   int green_run;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int rr(input int p, input logic [N-1:0] s);
      for (int k = 1; k <= N; k++) begin
         if (s[(p + k) % N]) return (p + k) % N;
      end
      return p;
   endfunction

   function automatic logic [2*N-1:0] exp_lights();
      logic [2*N-1:0] l;
      l = '0;
      if (m_mode == M_GRN) l[2*m_phase +: 2] = 2'b10;
      if (m_mode == M_YEL) l[2*m_phase +: 2] = 2'b01;
      return l;
   endfunction

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_phase = N - 1;
      m_last  = N - 1;
      m_cnt   = 0;
      m_start = 1'b0;
      green_run = 0;
   endtask

   task automatic enter_green(input int from, input logic [N-1:0] s);
      m_mode  = M_GRN;
      m_phase = rr(from, s);
      m_cnt   = 1;
      m_start = 1'b1;
   endtask

   task automatic model_step(input logic [N-1:0] s);
      logic others;
      others  = |(s & ~(N'(1) << m_phase));
      m_start = 1'b0;
      case (m_mode)
         M_IDLE: if (s != 0) enter_green(m_last, s);
         M_GRN: begin
            if ((m_cnt >= GMIN && (others || !s[m_phase])) || m_cnt == GMAX) begin
               m_mode = M_YEL;
               m_cnt  = 1;
            end else m_cnt++;
         end
         default: begin
            if (m_cnt == YT) begin
               m_last = m_phase;
               if (s != 0) enter_green(m_phase, s);
               else m_mode = M_IDLE;
            end else m_cnt++;
         end
      endcase
   endtask

   task automatic check_outputs();
      logic g_now;
      check_val("lights", 32'(bus.lights), 32'(exp_lights()));
      check_val("active_phase", 32'(bus.active_phase), (m_mode == M_IDLE) ? m_last : m_phase);
      check_val("busy", 32'(bus.busy), 32'(m_mode != M_IDLE));
      check_val("phase_start", 32'(bus.phase_start), 32'(m_start));
      g_now = 1'b0;
      for (int i = 0; i < N; i++) if (bus.lights[2*i +: 2] == 2'b10) g_now = 1'b1;
      if (g_now) green_run++;
      else if (green_run > 0) begin
         check_val("green_len_bound", 32'(green_run >= GMIN && green_run <= GMAX), 1);
         green_run = 0;
      end
   endtask

   task automatic run_cycle(input logic [N-1:0] s);
      bus.sensor = s;
      model_step(s);
      @(negedge clk);
      check_outputs();
   endtask

   // Called just after a negedge: drops reset between edges and checks the
   // outputs go safe before any clock edge arrives.
   task automatic do_reset(input int hold);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("rst_lights", 32'(bus.lights), 0);
      check_val("rst_busy", 32'(bus.busy), 0);
      check_val("rst_active", 32'(bus.active_phase), N - 1);
      check_val("rst_start", 32'(bus.phase_start), 0);
      model_reset();
      repeat (hold) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] s;
      int hold;
      reset_n    = 1'b0;
      bus.sensor = '0;
      model_reset();
      #1;
      check_val("init_lights", 32'(bus.lights), 0);
      check_val("init_busy", 32'(bus.busy), 0);
      repeat (10) @(negedge clk);
      check_val("hold_lights", 32'(bus.lights), 0);
      check_val("hold_active", 32'(bus.active_phase), N - 1);
      reset_n = 1'b1;

      repeat (5) run_cycle(3'b000);
      repeat (25) run_cycle(3'b001);
      repeat (12) run_cycle(3'b000);
      repeat (2) run_cycle(3'b001);
      repeat (10) run_cycle(3'b000);
      check_val("drop_idle_busy", 32'(bus.busy), 0);
      check_val("drop_idle_active", 32'(bus.active_phase), 0);
      repeat (30) run_cycle(3'b011);
      repeat (40) run_cycle(3'b111);

      for (int i = 0; i < 60 && !(m_mode == M_YEL && m_phase == 2); i++) run_cycle(3'b111);
      check_val("reach_yellow2", 32'(m_mode == M_YEL && m_phase == 2), 1);
      do_reset(3);
      run_cycle(3'b100);
      check_val("post_rst_green2", 32'(bus.lights), 32'(6'b100000));
      repeat (14) run_cycle(3'b100);

      for (int c = 0; c < 1500; ) begin
         s    = N'($urandom_range(0, (1 << N) - 1));
         hold = $urandom_range(1, 12);
         for (int j = 0; j < hold; j++) begin
            if ($urandom_range(0, 9) == 0) s[$urandom_range(0, N - 1)] ^= 1'b1;
            run_cycle(s);
         end
         c += hold;
         if (c >= 700 && c < 700 + hold) do_reset(2);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
